// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two-master request/response bus plus single-port data-memory bus.
// Ports: m_* are per-master (master i on lane i), s_* face the data memory.
// Modports: slave = arbiter side, master = environment side (masters and memory).
interface dmem_arbiter_if;
  logic [1:0]  m_req, m_lock, m_write, m_gnt, m_rvalid, m_err;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  logic [31:0] m_rdata;
  logic        s_req, s_sel, s_write, s_gnt, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  modport slave (
    input  m_req, m_lock, m_addr, m_be, m_write, m_wdata, s_gnt, s_rvalid, s_rdata,
    output m_gnt, m_rvalid, m_err, m_rdata, s_req, s_sel, s_write, s_addr, s_be, s_wdata
  );
  modport master (
    output m_req, m_lock, m_addr, m_be, m_write, m_wdata, s_gnt, s_rvalid, s_rdata,
    input  m_gnt, m_rvalid, m_err, m_rdata, s_req, s_sel, s_write, s_addr, s_be, s_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter onto a single data-memory port with window decode and lock.
// Ports: HCLK, HRESETn (async, active-low), bus (dmem_arbiter_if.slave).
// Config: define DMEM_ARB_RR_EN for round-robin IDLE arbitration; default is fixed priority (master 0 first).
module dmem_arbiter #(
  parameter logic [31:0] dmem_addr_low  = 32'h00100000,
  parameter logic [31:0] dmem_addr_high = 32'h00108000
) (
  input logic           HCLK,
  input logic           HRESETn,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t      state;
  logic        owner, err, outstanding;
  logic        hold, any, sel, pick, in_win, mem_go, gnt, rsp;
  logic [1:0]  elig;
  logic [31:0] w_addr;
`ifdef DMEM_ARB_RR_EN
  logic ptr;
  assign pick = ptr;
`else
  assign pick = 1'b0;
`endif
  // hold: the locked master keeps ownership; otherwise a lock state behaves like IDLE
  // with the previously locked master excluded for this cycle.
  always_comb begin
    hold   = (state == LOCK0 && bus.m_req[0] && bus.m_lock[0]) ||
             (state == LOCK1 && bus.m_req[1] && bus.m_lock[1]);
    elig   = state == LOCK0 ? (hold ? 2'b01 : bus.m_req & 2'b10) :
             state == LOCK1 ? (hold ? 2'b10 : bus.m_req & 2'b01) : bus.m_req;
    elig   = HRESETn ? elig : 2'b00;
    any    = |elig;
    sel    = elig == 2'b11 ? pick : elig[1];
    w_addr = sel ? bus.m_addr[63:32] : bus.m_addr[31:0];
    in_win = w_addr >= dmem_addr_low && w_addr < dmem_addr_high;
    mem_go = any && in_win;
    gnt    = any && (in_win ? bus.s_gnt : 1'b1);
    rsp    = outstanding && (err || bus.s_rvalid);
  end
  assign bus.s_req    = mem_go;
  assign bus.s_sel    = mem_go;
  assign bus.s_write  = mem_go && (sel ? bus.m_write[1] : bus.m_write[0]);
  assign bus.s_addr   = mem_go ? w_addr : '0;
  assign bus.s_be     = mem_go ? (sel ? bus.m_be[7:4] : bus.m_be[3:0]) : '0;
  assign bus.s_wdata  = mem_go ? (sel ? bus.m_wdata[63:32] : bus.m_wdata[31:0]) : '0;
  assign bus.m_gnt    = gnt ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_rvalid = rsp ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_err    = rsp && err ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_rdata  = rsp && !err ? bus.s_rdata : '0;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state       <= IDLE;
      owner       <= 1'b0;
      err         <= 1'b0;
      outstanding <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      ptr         <= 1'b0;
`endif
    end else begin
      outstanding <= gnt;
      if (gnt) begin
        owner <= sel;
        err   <= !in_win;
      end
      state <= hold ? state :
               gnt && (sel ? bus.m_lock[1] : bus.m_lock[0]) ? (sel ? LOCK1 : LOCK0) : IDLE;
`ifdef DMEM_ARB_RR_EN
      if (gnt && !hold) ptr <= !sel;
`endif
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;
  localparam logic [31:0] LOW  = 32'h00100000;
  localparam logic [31:0] HIGH = 32'h00108000;
  localparam logic [31:0] WD0  = 32'hA5A5A5A5;
  localparam logic [31:0] WD1  = 32'h5A5A5A5A;
  typedef struct {logic m; logic e; logic [31:0] rd; int due;} rsp_t;
  logic HCLK, HRESETn, stray, rv_q;
  logic [31:0] rd_q;
  logic [31:0] mem [0:255];
  logic [108:0] all_out;
  int tests, fails, cyc;
  rsp_t q[$];
  dmem_arbiter_if bus ();
  dmem_arbiter dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;
  assign all_out = {bus.m_gnt, bus.m_rvalid, bus.m_err, bus.m_rdata, bus.s_req, bus.s_sel,
                    bus.s_write, bus.s_addr, bus.s_be, bus.s_wdata};
  always @(posedge HCLK) begin
    rv_q <= bus.s_req && bus.s_gnt;
    rd_q <= bus.s_write ? bus.s_wdata : mem[bus.s_addr[9:2]];
    if (bus.s_req && bus.s_gnt && bus.s_write) mem[bus.s_addr[9:2]] <= bus.s_wdata;
  end
  assign bus.s_rvalid = rv_q | stray;
  assign bus.s_rdata  = rd_q;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic in_win(input logic [31:0] a);
    return a >= LOW && a < HIGH;
  endfunction
  always @(negedge HCLK) begin
    rsp_t r;
    if (q.size() != 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      chk("rvalid", 128'(bus.m_rvalid), 128'(r.m ? 2'b10 : 2'b01));
      chk("err", 128'(bus.m_err), 128'(r.e ? (r.m ? 2'b10 : 2'b01) : 2'b00));
      chk("rdata", 128'(bus.m_rdata), 128'(r.rd));
    end else chk("no_rvalid", 128'(bus.m_rvalid), 128'(0));
  end
  task automatic step(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] wr,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] rd,
                      input logic [1:0] eg, input logic es);
    logic m, e;
    bus.m_req = req;
    bus.m_lock = lock;
    bus.m_write = wr;
    bus.m_addr = {a1, a0};
    @(negedge HCLK);
    chk("gnt", 128'(bus.m_gnt), 128'(eg));
    chk("s_req", 128'(bus.s_req), 128'(es));
    if (eg != 2'b00) begin
      m = eg[1];
      e = !in_win(m ? a1 : a0);
      if (es) chk("s_addr", 128'(bus.s_addr), 128'(m ? a1 : a0));
      q.push_back('{m, e, e ? 32'h0 : wr[m] ? (m ? WD1 : WD0) : rd, cyc + 1});
    end else if (!es) chk("s_idle", 128'({bus.s_write, bus.s_be, bus.s_addr, bus.s_wdata}), 128'(0));
    @(posedge HCLK);
    #1;
  endtask
  initial begin
    logic [1:0] eg;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    HRESETn = 1'b0;
    stray = 1'b0;
    rv_q = 1'b0;
    rd_q = 32'h0;
    bus.s_gnt = 1'b1;
    bus.m_be = 8'hFF;
    bus.m_wdata = {WD1, WD0};
    bus.m_req = 2'b11;
    bus.m_lock = 2'b11;
    bus.m_write = 2'b11;
    bus.m_addr = {32'h00100100, 32'h00100000};
    #12 chk("rst_out", 128'(all_out), 128'(0));
    bus.m_req = 2'b00;
    bus.m_lock = 2'b00;
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    step(2'b01, 2'b00, 2'b01, 32'h00100010, 32'h0, 32'h0, 2'b01, 1'b1);
    step(2'b01, 2'b00, 2'b00, 32'h00100010, 32'h0, WD0, 2'b01, 1'b1);
    step(2'b01, 2'b00, 2'b00, LOW, 32'h0, 32'h0, 2'b01, 1'b1);
    step(2'b01, 2'b00, 2'b00, HIGH - 32'd4, 32'h0, 32'h0, 2'b01, 1'b1);
    step(2'b01, 2'b00, 2'b00, HIGH, 32'h0, 32'h0, 2'b01, 1'b0);
    step(2'b01, 2'b00, 2'b00, LOW - 32'd4, 32'h0, 32'h0, 2'b01, 1'b0);
    bus.s_gnt = 1'b0;
    step(2'b01, 2'b00, 2'b00, LOW, 32'h0, 32'h0, 2'b00, 1'b1);
    bus.s_gnt = 1'b1;
    stray = 1'b1;
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    stray = 1'b0;
    step(2'b10, 2'b00, 2'b00, 32'h0, 32'h00200000, 32'h0, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      eg = i % 2 == 1 ? 2'b10 : 2'b01;
`else
      eg = 2'b01;
`endif
      step(2'b11, 2'b00, 2'b11, 32'h00100020, 32'h00100040, 32'h0, eg, 1'b1);
    end
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    step(2'b10, 2'b10, 2'b00, 32'h00100080, 32'h001000C0, 32'h0, 2'b10, 1'b1);
    step(2'b11, 2'b10, 2'b00, 32'h00100080, 32'h001000C0, 32'h0, 2'b10, 1'b1);
    step(2'b11, 2'b10, 2'b00, 32'h00100080, 32'h001000C0, 32'h0, 2'b10, 1'b1);
    step(2'b01, 2'b00, 2'b00, 32'h00100080, 32'h001000C0, 32'h0, 2'b01, 1'b1);
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    step(2'b10, 2'b10, 2'b00, 32'h0, 32'h001000C0, 32'h0, 2'b10, 1'b1);
    HRESETn = 1'b0;
    q.delete();
    #1 chk("rst_mid", 128'(all_out), 128'(0));
    bus.m_req = 2'b00;
    bus.m_lock = 2'b00;
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    step(2'b11, 2'b10, 2'b00, LOW, 32'h001000C0, 32'h0, 2'b01, 1'b1);
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    chk("drain", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter dmem_addr_low, default 32'h00100000, meaning the inclusive lower bound of the data memory window.
REQ-002 The block SHALL have parameter dmem_addr_high, default 32'h00108000, meaning the exclusive upper bound of the data memory window.
REQ-003 HCLK  input  1  clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 m_req  input  [1:0]  per-master request; bit 0 = core data port, bit 1 = debug/loader port.
REQ-006 m_lock  input  [1:0]  per-master lock; holds ownership across back-to-back accesses.
REQ-007 m_addr  input  [63:0]  per-master byte address; master i on bits [32i+31:32i].
REQ-008 m_be  input  [7:0]  per-master byte enables; master i on bits [4i+3:4i].
REQ-009 m_write  input  [1:0]  per-master write strobe.
REQ-010 m_wdata  input  [63:0]  per-master write data; master i on bits [32i+31:32i].
REQ-011 m_gnt  output  [1:0]  per-master grant.
REQ-012 m_rvalid  output  [1:0]  per-master response valid.
REQ-013 m_err  output  [1:0]  per-master decode error, qualified by m_rvalid.
REQ-014 m_rdata  output  32  read data, shared by both masters, qualified by m_rvalid.
REQ-015 s_req, s_sel, s_write  output  1 each  memory request, window select and write strobe.
REQ-016 s_addr, s_wdata  output  32 each; s_be  output  4  memory address, write data and byte enables.
REQ-017 s_gnt, s_rvalid  input  1 each; s_rdata  input  32  memory grant, response valid and read data.

Function
REQ-018 A request SHALL be in-window when dmem_addr_low <= addr < dmem_addr_high, using unsigned 32-bit compare.
REQ-019 Each cycle the arbiter SHALL select at most one winner among asserted m_req bits, from arbitration state (IDLE, LOCK0, LOCK1) and priority pointer.
- IDLE: pointer/priority decides.
- LOCK0 or LOCK1: only the locked master is eligible.
REQ-020 Winner in-window: s_req=1, s_sel=1; s_addr/s_be/s_write/s_wdata driven from winner; m_gnt[winner]=s_gnt, combinational, same cycle.
REQ-021 Winner out-of-window: s_req=0, s_sel=0; m_gnt[winner]=1 same cycle; next cycle m_rvalid[winner]=1, m_err[winner]=1, m_rdata=32'h0; no memory write.
REQ-022 No winner: s_req=0, s_sel=0, s_write=0; s_addr, s_be and s_wdata SHALL be 0.
REQ-023 On every granted transfer, owner register (1 bit) and err flag SHALL capture winner and decode result.
REQ-024 Response latency SHALL be exactly one cycle after grant.
REQ-025 m_rvalid[owner] SHALL equal s_rvalid for in-window transfers; m_rdata=s_rdata; other master's m_rvalid=0.
REQ-026 Back-to-back grants to alternating masters SHALL be supported with no bubble; owner routing SHALL follow the grant one cycle earlier.
REQ-027 State transitions:
- IDLE->LOCKi when master i is granted with m_lock[i]=1.
- LOCKi->IDLE on the first cycle m_lock[i]=0 or m_req[i]=0; no grant is issued in that cycle unless the other master wins from IDLE priority.
REQ-028 Stray s_rvalid with no outstanding transfer SHALL be ignored; m_rvalid=0.
REQ-029 Simultaneous m_req=2'b11 in IDLE SHALL be resolved per REQ-035/REQ-036; the loser SHALL see m_gnt=0 and keep its request pending.

Reset
REQ-030 HRESETn low SHALL asynchronously force state=IDLE, pointer=0, owner=0, err=0, outstanding=0.
REQ-031 During reset all outputs SHALL be 0: m_gnt, m_rvalid, m_err, m_rdata, s_req, s_sel, s_write, s_addr, s_be, s_wdata.
REQ-032 Reset asserted mid-transfer SHALL drop any pending response; no m_rvalid after release for pre-reset grants.
REQ-033 First grant SHALL be possible in the first cycle after HRESETn deasserts.

Configuration
REQ-034 Macro DMEM_ARB_RR_EN SHALL select the IDLE arbitration policy.
REQ-035 With DMEM_ARB_RR_EN defined: round-robin.
- The pointer SHALL flip to the non-winner after each grant.
- The pointer SHALL be unchanged while locked.
REQ-036 Without DMEM_ARB_RR_EN: fixed priority, master 0 over master 1; pointer register absent.

Verification
REQ-037 m_req=01, m_addr[31:0]=0x00100010, write, be=0xF, data 0xA5A5A5A5 -> s_req=1, s_addr=0x00100010, m_gnt=01; readback next cycle gives m_rvalid=01, m_rdata=0xA5A5A5A5.
REQ-038 m_req=11 for 4 cycles, both in-window -> grants 01,10,01,10 (RR_EN) or 01,01,01,01 (no RR_EN); m_rvalid follows each grant by 1 cycle.
REQ-039 m_req[1]=1, m_addr[63:32]=0x00200000 -> m_gnt=10, s_req=0; next cycle m_rvalid=10, m_err=10, m_rdata=0.
REQ-040 m_lock[1]=1 with 3 back-to-back master-1 requests while m_req[0]=1 -> master 1 granted 3 times, master 0 granted on the cycle after lock drops.
REQ-041 HRESETn pulsed low in the cycle after a grant -> no m_rvalid; all outputs 0; state IDLE after release.
